control_sequencer: RTL and testbench



---
 rtl/cpu_ctrl_pkg.sv | 35 +++
 rtl/control_sequencer.sv | 163 ++++++++++++++++
 tb/tb_control_sequencer.sv | 267 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/cpu_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cpu_ctrl_pkg
// Description : Opcodes, ALU codes and sequencer state encoding for the RISC
//               CPU hard-wired control unit.
// Revision    : 1.0 - initial release
// ============================================================================
package cpu_ctrl_pkg;

    localparam logic [4:0] OP_BR   = 5'b10010;
    localparam logic [4:0] OP_JR   = 5'b10011;
    localparam logic [4:0] OP_JAL  = 5'b10100;
    localparam logic [4:0] OP_NOP  = 5'b11001;
    localparam logic [4:0] OP_HALT = 5'b11010;

    localparam logic [4:0] ALU_NONE = 5'b00000;
    localparam logic [4:0] ALU_ADD  = 5'b00011;

    typedef enum logic [3:0] {
        RESET  = 4'd0,
        T0     = 4'd1,
        T1     = 4'd2,
        T2     = 4'd3,
        BR_T3  = 4'd4,
        BR_T4  = 4'd5,
        BR_T5  = 4'd6,
        BR_T6  = 4'd7,
        JR_T3  = 4'd8,
        JAL_T3 = 4'd9,
        JAL_T4 = 4'd10,
        HALT   = 4'd11
    } state_t;

endpackage
`default_nettype wire

// File: rtl/control_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : control_sequencer
// Description : Step-counter control unit; fetch (T0-T2) then per-opcode
//               execute steps, driving every DataPath control input.
// Revision    : 1.0 - initial release
// ============================================================================
module control_sequencer #(
    parameter logic [4:0] ALU_ADD = cpu_ctrl_pkg::ALU_ADD
) (
    input  logic       clock,
    input  logic       clear,
    input  logic [4:0] opcode,
    input  logic       con_ff,
    input  logic       mem_wait,
    output logic       PCout,
    output logic       IncPC,
    output logic       MARin,
    output logic       ZLOin,
    output logic       read,
    output logic       RAMenable,
    output logic       MDRin,
    output logic       ZLOout,
    output logic       PCin,
    output logic       MDRout,
    output logic       IRin,
    output logic       Gra,
    output logic       Rout,
    output logic       conin,
    output logic       Yin,
    output logic       Cout,
    output logic       R15in,
    output logic [4:0] aluControl,
    output logic       running,
    output logic       illegal
);
    import cpu_ctrl_pkg::*;

    state_t r_state;
    state_t w_next_state;
    logic   r_illegal;
    logic   w_set_illegal;

    always_comb begin
        w_next_state  = r_state;
        w_set_illegal = 1'b0;
        case (r_state)
            RESET:  w_next_state = T0;
            T0:     w_next_state = T1;
            T1:     w_next_state = mem_wait ? T1 : T2;
            T2: begin
                case (opcode)
                    OP_BR:   w_next_state = BR_T3;
                    OP_JR:   w_next_state = JR_T3;
                    OP_JAL:  w_next_state = JAL_T3;
                    OP_NOP:  w_next_state = T0;
                    OP_HALT: w_next_state = HALT;
                    default: begin
                        w_next_state  = T0;
                        w_set_illegal = 1'b1;
                    end
                endcase
            end
            BR_T3:  w_next_state = BR_T4;
            BR_T4:  w_next_state = BR_T5;
            BR_T5:  w_next_state = BR_T6;
            BR_T6:  w_next_state = T0;
            JR_T3:  w_next_state = T0;
            JAL_T3: w_next_state = JAL_T4;
            JAL_T4: w_next_state = T0;
            HALT:   w_next_state = HALT;
            default: w_next_state = RESET;
        endcase
    end

    always_ff @(posedge clock) begin
        if (clear) begin
            r_state   <= RESET;
            r_illegal <= 1'b0;
        end else begin
            r_state <= w_next_state;
            if (w_set_illegal) begin
                r_illegal <= 1'b1;
            end
        end
    end

    // Moore decode from r_state; only T1 (mem_wait) and BR_T6 (con_ff) look at inputs.
    always_comb begin
        PCout      = 1'b0;
        IncPC      = 1'b0;
        MARin      = 1'b0;
        ZLOin      = 1'b0;
        read       = 1'b0;
        RAMenable  = 1'b0;
        MDRin      = 1'b0;
        ZLOout     = 1'b0;
        PCin       = 1'b0;
        MDRout     = 1'b0;
        IRin       = 1'b0;
        Gra        = 1'b0;
        Rout       = 1'b0;
        conin      = 1'b0;
        Yin        = 1'b0;
        Cout       = 1'b0;
        R15in      = 1'b0;
        aluControl = ALU_NONE;
        case (r_state)
            T0: begin
                PCout = 1'b1;
                MARin = 1'b1;
                IncPC = 1'b1;
                ZLOin = 1'b1;
            end
            T1: begin
                read      = 1'b1;
                RAMenable = 1'b1;
                MDRin     = 1'b1;
                ZLOout    = ~mem_wait;
                PCin      = ~mem_wait;
            end
            T2: begin
                MDRout = 1'b1;
                IRin   = 1'b1;
            end
            BR_T3: begin
                Gra   = 1'b1;
                Rout  = 1'b1;
                conin = 1'b1;
            end
            BR_T4: begin
                PCout = 1'b1;
                Yin   = 1'b1;
            end
            BR_T5: begin
                Cout       = 1'b1;
                aluControl = ALU_ADD;
                ZLOin      = 1'b1;
            end
            BR_T6: begin
                ZLOout = 1'b1;
                PCin   = con_ff;
            end
            JR_T3, JAL_T4: begin
                Gra  = 1'b1;
                Rout = 1'b1;
                PCin = 1'b1;
            end
            JAL_T3: begin
                PCout = 1'b1;
                R15in = 1'b1;
            end
            default: begin
                PCout = 1'b0;
            end
        endcase
    end

    assign running = (r_state != RESET) && (r_state != HALT);
    assign illegal = r_illegal;

endmodule
`default_nettype wire

// File: tb/tb_control_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_control_sequencer
// Description : Directed self-checking bench for control_sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_control_sequencer;

    logic       clock = 1'b0;
    logic       clear;
    logic [4:0] opcode;
    logic       con_ff;
    logic       mem_wait;
    logic PCout, IncPC, MARin, ZLOin, read, RAMenable, MDRin, ZLOout, PCin;
    logic MDRout, IRin, Gra, Rout, conin, Yin, Cout, R15in;
    logic [4:0] aluControl;
    logic       running;
    logic       illegal;

    int n_pass  = 0;
    int n_total = 0;

    always #5 clock = ~clock;

    control_sequencer #(.ALU_ADD(5'b00011)) dut (
        .clock(clock), .clear(clear), .opcode(opcode), .con_ff(con_ff), .mem_wait(mem_wait),
        .PCout(PCout), .IncPC(IncPC), .MARin(MARin), .ZLOin(ZLOin), .read(read),
        .RAMenable(RAMenable), .MDRin(MDRin), .ZLOout(ZLOout), .PCin(PCin),
        .MDRout(MDRout), .IRin(IRin), .Gra(Gra), .Rout(Rout), .conin(conin),
        .Yin(Yin), .Cout(Cout), .R15in(R15in), .aluControl(aluControl),
        .running(running), .illegal(illegal)
    );

    // Bit order: PCout IncPC MARin ZLOin read RAMenable MDRin ZLOout PCin MDRout IRin Gra Rout conin Yin Cout R15in
    logic [16:0] w_ctl;
    assign w_ctl = {PCout, IncPC, MARin, ZLOin, read, RAMenable, MDRin, ZLOout, PCin,
                    MDRout, IRin, Gra, Rout, conin, Yin, Cout, R15in};

    localparam logic [16:0] E_NONE  = 17'h00000;
    localparam logic [16:0] E_T0    = 17'h1E000;
    localparam logic [16:0] E_T1W   = 17'h01C00;
    localparam logic [16:0] E_T1    = 17'h01F00;
    localparam logic [16:0] E_T2    = 17'h000C0;
    localparam logic [16:0] E_BR3   = 17'h00038;
    localparam logic [16:0] E_BR4   = 17'h10004;
    localparam logic [16:0] E_BR5   = 17'h02002;
    localparam logic [16:0] E_BR6_1 = 17'h00300;
    localparam logic [16:0] E_BR6_0 = 17'h00200;
    localparam logic [16:0] E_JR3   = 17'h00130;
    localparam logic [16:0] E_JAL3  = 17'h10001;
    localparam logic [16:0] E_JAL4  = 17'h00130;

    localparam logic [4:0] K_BR   = 5'b10010;
    localparam logic [4:0] K_JR   = 5'b10011;
    localparam logic [4:0] K_JAL  = 5'b10100;
    localparam logic [4:0] K_NOP  = 5'b11001;
    localparam logic [4:0] K_HALT = 5'b11010;
    localparam logic [4:0] K_BAD  = 5'b01111;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset();
        clear = 1'b1; opcode = K_NOP; con_ff = 1'b0; mem_wait = 1'b0;
        for (int i = 0; i < 2; i++) begin
            tick();
            n_total++;
            if (w_ctl !== E_NONE || aluControl !== 5'd0 || running !== 1'b0 || illegal !== 1'b0)
                $display("FAIL reset_hold%0d: got ctl=%h alu=%b run=%b ill=%b, want ctl=0 alu=0 run=0 ill=0",
                         i, w_ctl, aluControl, running, illegal);
            else n_pass++;
        end
        clear = 1'b0;
        #1;
        n_total++;
        if (w_ctl !== E_NONE || running !== 1'b0)
            $display("FAIL reset_release: got ctl=%h run=%b, want ctl=0 run=0", w_ctl, running);
        else n_pass++;
        tick();
        n_total++;
        if (w_ctl !== E_T0 || running !== 1'b1 || illegal !== 1'b0)
            $display("FAIL reset_first_t0: got ctl=%h run=%b ill=%b, want ctl=%h run=1 ill=0",
                     w_ctl, running, illegal, E_T0);
        else n_pass++;
    endtask

    task automatic test_fetch_wait();
        logic [16:0] exp_ctl [7];
        logic        mw      [7];
        exp_ctl = '{E_T0, E_T1W, E_T1W, E_T1W, E_T1, E_T2, E_T0};
        mw      = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        opcode = K_NOP;
        for (int i = 0; i < 7; i++) begin
            mem_wait = mw[i];
            #1;
            n_total++;
            if (w_ctl !== exp_ctl[i] || aluControl !== 5'd0 || running !== 1'b1 || illegal !== 1'b0)
                $display("FAIL fetch_wait step%0d: got ctl=%h alu=%b run=%b ill=%b, want ctl=%h alu=0 run=1 ill=0",
                         i, w_ctl, aluControl, running, illegal, exp_ctl[i]);
            else n_pass++;
            if (i < 6) tick();
        end
        mem_wait = 1'b0;
    endtask

    task automatic test_br(input logic cf);
        logic [16:0] exp_ctl [8];
        logic [4:0]  exp_alu [8];
        exp_ctl = '{E_T0, E_T1, E_T2, E_BR3, E_BR4, E_BR5, (cf ? E_BR6_1 : E_BR6_0), E_T0};
        exp_alu = '{5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'b00011, 5'd0, 5'd0};
        opcode = K_BR; con_ff = cf; mem_wait = 1'b0;
        for (int i = 0; i < 8; i++) begin
            #1;
            n_total++;
            if (w_ctl !== exp_ctl[i] || aluControl !== exp_alu[i] || running !== 1'b1 || illegal !== 1'b0)
                $display("FAIL br_cf%0b step%0d: got ctl=%h alu=%b run=%b ill=%b, want ctl=%h alu=%b run=1 ill=0",
                         cf, i, w_ctl, aluControl, running, illegal, exp_ctl[i], exp_alu[i]);
            else n_pass++;
            if (i == 6) begin
                con_ff = ~cf;
                #1;
                n_total++;
                if (PCin !== ~cf)
                    $display("FAIL br_passthrough: got PCin=%b, want PCin=%b", PCin, ~cf);
                else n_pass++;
                con_ff = cf;
            end
            if (i < 7) tick();
        end
    endtask

    task automatic test_jal();
        logic [16:0] exp_ctl [6];
        logic        mw      [6];
        exp_ctl = '{E_T0, E_T1, E_T2, E_JAL3, E_JAL4, E_T0};
        mw      = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
        opcode = K_JAL;
        for (int i = 0; i < 6; i++) begin
            mem_wait = mw[i];
            #1;
            n_total++;
            if (w_ctl !== exp_ctl[i] || aluControl !== 5'd0 || running !== 1'b1 || illegal !== 1'b0)
                $display("FAIL jal step%0d: got ctl=%h alu=%b run=%b ill=%b, want ctl=%h alu=0 run=1 ill=0",
                         i, w_ctl, aluControl, running, illegal, exp_ctl[i]);
            else n_pass++;
            if (i < 5) tick();
        end
        mem_wait = 1'b0;
    endtask

    task automatic test_jr(input logic exp_ill);
        logic [16:0] exp_ctl [5];
        logic        mw      [5];
        exp_ctl = '{E_T0, E_T1, E_T2, E_JR3, E_T0};
        mw      = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
        opcode = K_JR;
        for (int i = 0; i < 5; i++) begin
            mem_wait = mw[i];
            #1;
            n_total++;
            if (w_ctl !== exp_ctl[i] || aluControl !== 5'd0 || running !== 1'b1 || illegal !== exp_ill)
                $display("FAIL jr step%0d: got ctl=%h alu=%b run=%b ill=%b, want ctl=%h alu=0 run=1 ill=%b",
                         i, w_ctl, aluControl, running, illegal, exp_ctl[i], exp_ill);
            else n_pass++;
            if (i < 4) tick();
        end
        mem_wait = 1'b0;
    endtask

    task automatic test_illegal();
        logic [16:0] exp_ctl [4];
        logic        exp_ill [4];
        exp_ctl = '{E_T0, E_T1, E_T2, E_T0};
        exp_ill = '{1'b0, 1'b0, 1'b0, 1'b1};
        opcode = K_BAD; mem_wait = 1'b0;
        for (int i = 0; i < 4; i++) begin
            #1;
            n_total++;
            if (w_ctl !== exp_ctl[i] || running !== 1'b1 || illegal !== exp_ill[i])
                $display("FAIL illegal step%0d: got ctl=%h run=%b ill=%b, want ctl=%h run=1 ill=%b",
                         i, w_ctl, running, illegal, exp_ctl[i], exp_ill[i]);
            else n_pass++;
            if (i < 3) tick();
        end
    endtask

    task automatic test_clear_mid();
        logic [16:0] exp_ctl [6];
        logic [16:0] nop_ctl [4];
        exp_ctl = '{E_T0, E_T1, E_T2, E_BR3, E_BR4, E_BR5};
        nop_ctl = '{E_T0, E_T1, E_T2, E_T0};
        opcode = K_BR; con_ff = 1'b1; mem_wait = 1'b0;
        for (int i = 0; i < 6; i++) begin
            #1;
            n_total++;
            if (w_ctl !== exp_ctl[i] || illegal !== 1'b1)
                $display("FAIL clear_mid_br step%0d: got ctl=%h ill=%b, want ctl=%h ill=1",
                         i, w_ctl, illegal, exp_ctl[i]);
            else n_pass++;
            if (i < 5) tick();
        end
        clear = 1'b1;
        tick();
        n_total++;
        if (w_ctl !== E_NONE || aluControl !== 5'd0 || running !== 1'b0 || illegal !== 1'b0)
            $display("FAIL clear_mid_reset: got ctl=%h alu=%b run=%b ill=%b, want ctl=0 alu=0 run=0 ill=0",
                     w_ctl, aluControl, running, illegal);
        else n_pass++;
        clear = 1'b0;
        opcode = K_NOP;
        tick();
        for (int i = 0; i < 4; i++) begin
            #1;
            n_total++;
            if (w_ctl !== nop_ctl[i] || running !== 1'b1 || illegal !== 1'b0)
                $display("FAIL clear_mid_refetch step%0d: got ctl=%h run=%b ill=%b, want ctl=%h run=1 ill=0",
                         i, w_ctl, running, illegal, nop_ctl[i]);
            else n_pass++;
            if (i < 3) tick();
        end
    endtask

    task automatic test_halt();
        logic [16:0] exp_ctl [3];
        exp_ctl = '{E_T0, E_T1, E_T2};
        opcode = K_HALT; mem_wait = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            n_total++;
            if (w_ctl !== exp_ctl[i] || running !== 1'b1)
                $display("FAIL halt_fetch step%0d: got ctl=%h run=%b, want ctl=%h run=1",
                         i, w_ctl, running, exp_ctl[i]);
            else n_pass++;
            tick();
        end
        for (int i = 0; i < 10; i++) begin
            mem_wait = i[0];
            #1;
            n_total++;
            if (w_ctl !== E_NONE || aluControl !== 5'd0 || running !== 1'b0 || illegal !== 1'b0)
                $display("FAIL halt_idle cycle%0d: got ctl=%h alu=%b run=%b ill=%b, want ctl=0 alu=0 run=0 ill=0",
                         i, w_ctl, aluControl, running, illegal);
            else n_pass++;
            tick();
        end
        mem_wait = 1'b0;
    endtask

    initial begin
        test_reset();
        test_fetch_wait();
        test_br(1'b1);
        test_br(1'b0);
        test_jal();
        test_jr(1'b0);
        test_illegal();
        test_jr(1'b1);
        test_clear_mid();
        test_halt();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
